// File: rtl/conv_wb_desc_gen_pkg.sv
// Shared definitions for the convolution write-back descriptor path:
// RTM geometry, FSM state encoding and descriptor field widths.
package conv_wb_desc_gen_pkg;

    localparam int RTM_DEPTH_DEFAULT = 16384;
    localparam int CNT_W_DEFAULT     = 16;

    // mask + last flags carried alongside the RTM address in each descriptor
    localparam int DESC_FLAG_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GEN     = 2'd1,
        WAIT_WB = 2'd2,
        FIN     = 2'd3
    } wb_state_e;

endpackage

// File: rtl/conv_wb_addr_cnt.sv
// Nested vector/group walker over the output tensor's RTM footprint.
// Presents the descriptor for the current position; advances on each push.
module conv_wb_addr_cnt
    import conv_wb_desc_gen_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              adv,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_grp_stride,
    input  logic [CNT_W-1:0]  cfg_n_vec,
    input  logic [CNT_W-1:0]  cfg_n_vec_pad,
    input  logic [CNT_W-1:0]  cfg_n_grp,
    output logic [ADDR_W-1:0] desc_addr,
    output logic              desc_mask,
    output logic              desc_last
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0]  v_q, g_q, n_vec_q, n_vec_pad_q, n_grp_q;
    logic [ADDR_W-1:0] grp_addr_q, stride_q;

    logic [CNT_W-1:0]  cur_v, cur_g, cur_n_vec, cur_n_vec_pad, cur_n_grp;
    logic [ADDR_W-1:0] cur_grp_addr, cur_stride;
    logic              vec_wrap;

    // On load the walk starts from the incoming config in the same cycle,
    // so the first descriptor can be pushed right after start.
    always_comb begin
        cur_v         = load ? '0 : v_q;
        cur_g         = load ? '0 : g_q;
        cur_grp_addr  = load ? cfg_base : grp_addr_q;
        cur_n_vec     = load ? cfg_n_vec : n_vec_q;
        cur_n_vec_pad = load ? cfg_n_vec_pad : n_vec_pad_q;
        cur_n_grp     = load ? cfg_n_grp : n_grp_q;
        cur_stride    = load ? cfg_grp_stride : stride_q;
        vec_wrap      = (cur_v == cur_n_vec_pad - ONE);
        desc_addr     = cur_grp_addr + ADDR_W'(cur_v);
        desc_mask     = (cur_v >= cur_n_vec);
        desc_last     = vec_wrap && (cur_g == cur_n_grp - ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q         <= '0;
            g_q         <= '0;
            grp_addr_q  <= '0;
            n_vec_q     <= '0;
            n_vec_pad_q <= '0;
            n_grp_q     <= '0;
            stride_q    <= '0;
        end else begin
            if (load) begin
                n_vec_q     <= cfg_n_vec;
                n_vec_pad_q <= cfg_n_vec_pad;
                n_grp_q     <= cfg_n_grp;
                stride_q    <= cfg_grp_stride;
            end
            if (adv) begin
                if (vec_wrap) begin
                    v_q        <= '0;
                    g_q        <= cur_g + ONE;
                    grp_addr_q <= cur_grp_addr + cur_stride;
                end else begin
                    v_q        <= cur_v + ONE;
                    g_q        <= cur_g;
                    grp_addr_q <= cur_grp_addr;
                end
            end else if (load) begin
                v_q        <= '0;
                g_q        <= '0;
                grp_addr_q <= cfg_base;
            end
        end
    end

endmodule

// File: rtl/conv_wb_desc_gen.sv
// Write-back descriptor generator: pushes one (addr, mask, last) descriptor per
// PPU output vector, then waits for the RTM writer before signalling done.
module conv_wb_desc_gen
    import conv_wb_desc_gen_pkg::*;
#(
    parameter int RTM_DEPTH = RTM_DEPTH_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT,
    localparam int ADDR_W   = $clog2(RTM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [CNT_W-1:0]  cfg_n_vec,
    input  logic [CNT_W-1:0]  cfg_n_vec_pad,
    input  logic [CNT_W-1:0]  cfg_n_grp,
    input  logic [ADDR_W-1:0] cfg_grp_stride,
    output logic              desc_fifo_wr_en,
    output logic [ADDR_W-1:0] desc_fifo_din_addr,
    output logic              desc_fifo_din_mask,
    output logic              desc_fifo_din_last,
    input  logic              desc_fifo_almost_full,
    input  logic              wb_done_pulse,
    output logic              busy,
    output logic              done
);

    wb_state_e         state;
    logic              wb_seen;
    logic              zero_cfg, load, push;
    logic [ADDR_W-1:0] nxt_addr;
    logic              nxt_mask, nxt_last;

    always_comb begin
        zero_cfg = (cfg_n_grp == '0) || (cfg_n_vec_pad == '0);
        load     = (state == IDLE) && start && !zero_cfg;
        push     = ((state == GEN) || load) && !desc_fifo_almost_full;
    end

    conv_wb_addr_cnt #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_addr_cnt (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (load),
        .adv            (push),
        .cfg_base       (cfg_base),
        .cfg_grp_stride (cfg_grp_stride),
        .cfg_n_vec      (cfg_n_vec),
        .cfg_n_vec_pad  (cfg_n_vec_pad),
        .cfg_n_grp      (cfg_n_grp),
        .desc_addr      (nxt_addr),
        .desc_mask      (nxt_mask),
        .desc_last      (nxt_last)
    );

    // wb_seen catches a writer done that races ahead of our final push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            wb_seen            <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            desc_fifo_wr_en    <= 1'b0;
            desc_fifo_din_addr <= '0;
            desc_fifo_din_mask <= 1'b0;
            desc_fifo_din_last <= 1'b0;
        end else begin
            desc_fifo_wr_en <= push;
            done            <= 1'b0;
            if (push) begin
                desc_fifo_din_addr <= nxt_addr;
                desc_fifo_din_mask <= nxt_mask;
                desc_fifo_din_last <= nxt_last;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        wb_seen <= 1'b0;
                        busy    <= 1'b1;
                        if (zero_cfg) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else if (push && nxt_last) begin
                            state <= WAIT_WB;
                        end else begin
                            state <= GEN;
                        end
                    end
                end
                GEN: begin
                    if (wb_done_pulse) wb_seen <= 1'b1;
                    if (push && nxt_last) state <= WAIT_WB;
                end
                WAIT_WB: begin
                    if (wb_done_pulse || wb_seen) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                    if (wb_done_pulse) wb_seen <= 1'b1;
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
